// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Sequencing controller owning a WIDTH-bit count register with
//               prescaled stepping, one-shot / auto-reload modes and pause.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4,
    parameter int RELOAD_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [WIDTH-1:0]      cfg_load_val,
    input  logic [WIDTH-1:0]      cfg_term_val,
    input  logic                  cfg_dir,
    input  logic                  cfg_auto_reload,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  tc_pulse,
    output logic                  done,
    output logic [RELOAD_W-1:0]   reload_cnt
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_PAUSED = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam logic [WIDTH-1:0]      c_Q_ONE      = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] c_PRESC_ONE  = PRESCALE_W'(1);
    localparam logic [RELOAD_W-1:0]   c_RELOAD_ONE = RELOAD_W'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic [WIDTH-1:0]      r_q;
    logic [PRESCALE_W-1:0] r_presc;
    logic [RELOAD_W-1:0]   r_reload;
    logic                  r_tc;

    logic [WIDTH-1:0]      r_sh_load;
    logic [WIDTH-1:0]      r_sh_term;
    logic                  r_sh_dir;
    logic                  r_sh_auto;
    logic [PRESCALE_W-1:0] r_sh_presc;

    logic w_idle_like;
    logic w_launch;
    logic w_run_active;
    logic w_step;
    logic w_at_term;
    logic w_terminal;
    logic w_reload_sat;

    // Priority rst > stop > start > pause > step is folded into these enables.
    assign w_idle_like  = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
    assign w_launch     = w_idle_like && start && !stop;
    assign w_run_active = (r_state == c_ST_RUN) && !stop && !pause;
    assign w_step       = w_run_active && (r_presc == r_sh_presc);
    assign w_at_term    = (r_q == r_sh_term);
    assign w_terminal   = w_step && w_at_term;
    assign w_reload_sat = &r_reload;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (stop) begin
                    w_next_state = c_ST_IDLE;
                end else if (start) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (stop) begin
                    w_next_state = c_ST_IDLE;
                end else if (pause) begin
                    w_next_state = c_ST_PAUSED;
                end else if (w_terminal && !r_sh_auto) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_PAUSED: begin
                if (stop) begin
                    w_next_state = c_ST_IDLE;
                end else if (!pause) begin
                    w_next_state = c_ST_RUN;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_RUN, c_ST_PAUSED: busy = 1'b1;
            c_ST_DONE:             done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign q          = r_q;
    assign tc_pulse   = r_tc;
    assign reload_cnt = r_reload;

    // ------------------------------------------------------------------
    // Shadow configuration, captured only when a sequence is launched
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_load  <= '0;
            r_sh_term  <= '0;
            r_sh_dir   <= 1'b0;
            r_sh_auto  <= 1'b0;
            r_sh_presc <= '0;
        end else if (w_launch) begin
            r_sh_load  <= cfg_load_val;
            r_sh_term  <= cfg_term_val;
            r_sh_dir   <= cfg_dir;
            r_sh_auto  <= cfg_auto_reload;
            r_sh_presc <= cfg_prescale;
        end
    end

    // ------------------------------------------------------------------
    // Count datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_presc  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= w_terminal;

            if (w_launch) begin
                r_q <= cfg_load_val;
            end else if (w_terminal) begin
                // One-shot holds term; auto-reload restarts from the load value.
                if (r_sh_auto) begin
                    r_q <= r_sh_load;
                end
            end else if (w_step) begin
                if (r_sh_dir) begin
                    r_q <= r_q - c_Q_ONE;
                end else begin
                    r_q <= r_q + c_Q_ONE;
                end
            end

            if (w_launch || w_step) begin
                r_presc <= '0;
            end else if (w_run_active) begin
                r_presc <= r_presc + c_PRESC_ONE;
            end

            if (w_launch) begin
                r_reload <= '0;
            end else if (w_terminal && r_sh_auto && !w_reload_sat) begin
                r_reload <= r_reload + c_RELOAD_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Scoreboard bench for counter_seq_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       tc;
        logic       done;
        logic [7:0] rc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] cfg_load_val;
    logic [3:0] cfg_term_val;
    logic       cfg_dir;
    logic       cfg_auto_reload;
    logic [3:0] cfg_prescale;
    logic [3:0] q;
    logic       busy;
    logic       tc_pulse;
    logic       done;
    logic [7:0] reload_cnt;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    counter_seq_ctrl #(
        .WIDTH      (4),
        .PRESCALE_W (4),
        .RELOAD_W   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .pause           (pause),
        .cfg_load_val    (cfg_load_val),
        .cfg_term_val    (cfg_term_val),
        .cfg_dir         (cfg_dir),
        .cfg_auto_reload (cfg_auto_reload),
        .cfg_prescale    (cfg_prescale),
        .q               (q),
        .busy            (busy),
        .tc_pulse        (tc_pulse),
        .done            (done),
        .reload_cnt      (reload_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{q: q, busy: busy, tc: tc_pulse, done: done, rc: reload_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got q=%0d busy=%b tc=%b done=%b rc=%0d, want q=%0d busy=%b tc=%b done=%b rc=%0d",
                         t, a.q, a.busy, a.tc, a.done, a.rc, e.q, e.busy, e.tc, e.done, e.rc);
            end
        end
    end

    // Apply the current inputs for one edge and queue the expected result.
    task automatic cyc(input logic [3:0] eq, input logic eb, input logic et,
                       input logic ed, input logic [7:0] er, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        e = '{q: eq, busy: eb, tc: et, done: ed, rc: er};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic set_cfg(input logic [3:0] ld, input logic [3:0] tm, input logic dr,
                           input logic ar, input logic [3:0] ps);
        cfg_load_val    = ld;
        cfg_term_val    = tm;
        cfg_dir         = dr;
        cfg_auto_reload = ar;
        cfg_prescale    = ps;
    endtask

    task automatic oneshot_up_0_to_5(input string tag);
        set_cfg(4'd0, 4'd5, 1'b0, 1'b0, 4'd0);
        start = 1'b1;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'd0, {tag, "_load"});
        start = 1'b0;
        for (int i = 1; i <= 5; i++) cyc(4'(i), 1'b1, 1'b0, 1'b0, 8'd0, {tag, "_count"});
        cyc(4'd5, 1'b0, 1'b1, 1'b1, 8'd0, {tag, "_terminal"});
        cyc(4'd5, 1'b0, 1'b0, 1'b1, 8'd0, {tag, "_done_hold"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got queue depth %0d, want 0", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        pause = 1'b1;
        set_cfg(4'd9, 4'd3, 1'b1, 1'b1, 4'd2);

        // Reset overrides start and pause
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "reset_1");
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "reset_2");
        rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_hold");

        // One-shot up, then restart from DONE and stop
        oneshot_up_0_to_5("oneshot");
        start = 1'b1;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'd0, "restart_from_done");
        start = 1'b0;
        stop  = 1'b1;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "stop_after_restart");
        stop  = 1'b0;

        // Auto-reload down with wrap through 0 -> 15
        set_cfg(4'd2, 4'd14, 1'b1, 1'b1, 4'd0);
        start = 1'b1;
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "down_load");
        start = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'(p - 1), "down_1");
            cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'(p - 1), "down_0");
            start = (p == 2);
            set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 4'd3);
            cyc(4'd15, 1'b1, 1'b0, 1'b0, 8'(p - 1), "down_wrap_15");
            start = 1'b0;
            cyc(4'd14, 1'b1, 1'b0, 1'b0, 8'(p - 1), "down_14");
            cyc(4'd2, 1'b1, 1'b1, 1'b0, 8'(p), "down_reload");
        end
        stop = 1'b1;
        cyc(4'd2, 1'b0, 1'b0, 1'b0, 8'd3, "down_stop");
        stop = 1'b0;

        // Prescale 2 with a pause in the middle of the q=1 interval
        set_cfg(4'd0, 4'd3, 1'b0, 1'b0, 4'd2);
        start = 1'b1;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'd0, "presc_load");
        start = 1'b0;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q0_b");
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q0_c");
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q1_enter");
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q1_run");
        pause = 1'b1;
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'd0, "pause_enter");
        set_cfg(4'd0, 4'd3, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'd0, "paused_frozen");
        pause = 1'b0;
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'd0, "pause_release");
        cyc(4'd1, 1'b1, 1'b0, 1'b0, 8'd0, "resume_q1_last");
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "resume_q2");
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q2_b");
        cyc(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q2_c");
        cyc(4'd3, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q3_a");
        cyc(4'd3, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q3_b");
        cyc(4'd3, 1'b1, 1'b0, 1'b0, 8'd0, "presc_q3_c");
        cyc(4'd3, 1'b0, 1'b1, 1'b1, 8'd0, "presc_terminal");

        // Config isolation and stop
        set_cfg(4'd0, 4'd9, 1'b0, 1'b0, 4'd0);
        start = 1'b1;
        cyc(4'd0, 1'b1, 1'b0, 1'b0, 8'd0, "iso_load");
        start = 1'b0;
        for (int i = 1; i <= 4; i++) cyc(4'(i), 1'b1, 1'b0, 1'b0, 8'd0, "iso_count");
        cfg_term_val = 4'd2;
        cfg_load_val = 4'd3;
        cyc(4'd5, 1'b1, 1'b0, 1'b0, 8'd0, "iso_cfg_ignored_5");
        cyc(4'd6, 1'b1, 1'b0, 1'b0, 8'd0, "iso_cfg_ignored_6");
        stop = 1'b1;
        cyc(4'd6, 1'b0, 1'b0, 1'b0, 8'd0, "stop_holds_q");
        stop = 1'b0;
        cyc(4'd6, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_stop");
        start = 1'b1;
        stop  = 1'b1;
        cyc(4'd6, 1'b0, 1'b0, 1'b0, 8'd0, "start_stop_idle");
        start = 1'b0;
        stop  = 1'b0;
        cyc(4'd6, 1'b0, 1'b0, 1'b0, 8'd0, "idle_no_load");

        // load == term: every step is a terminal event; then reset mid-run
        set_cfg(4'd7, 4'd7, 1'b0, 1'b1, 4'd0);
        start = 1'b1;
        cyc(4'd7, 1'b1, 1'b0, 1'b0, 8'd0, "eq_load");
        start = 1'b0;
        for (int i = 1; i <= 3; i++) cyc(4'd7, 1'b1, 1'b1, 1'b0, 8'(i), "eq_reload");
        pause = 1'b1;
        rst   = 1'b1;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "reset_mid_run");
        rst   = 1'b0;
        pause = 1'b0;
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_reset");
        oneshot_up_0_to_5("post_reset");

        // Reload counter saturation at 255
        set_cfg(4'd7, 4'd7, 1'b0, 1'b1, 4'd0);
        start = 1'b1;
        cyc(4'd7, 1'b1, 1'b0, 1'b0, 8'd0, "sat_load");
        start = 1'b0;
        for (int i = 1; i <= 258; i++) begin
            cyc(4'd7, 1'b1, 1'b1, 1'b0, (i > 255) ? 8'd255 : 8'(i), "sat_reload");
        end
        stop = 1'b1;
        cyc(4'd7, 1'b0, 1'b0, 1'b0, 8'd255, "sat_stop");
        stop = 1'b0;

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got queue depth %0d, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
